// File: rtl/src_pkg.sv
// Shared constants, state encoding and the control-word decoder for src_control_core.
// The decoder maps a state (plus the current opcode, for ALU selection) to every strobe.
package src_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_SHR = 4'd4, ALU_SHL = 4'd5, ALU_ROR = 4'd6, ALU_ROL = 4'd7,
    ALU_MUL = 4'd8, ALU_DIV = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11
  } alu_e;

  localparam logic [1:0] COND_ZERO = 2'b00;
  localparam logic [1:0] COND_NZ   = 2'b01;
  localparam logic [1:0] COND_POS  = 2'b10;
  localparam logic [1:0] COND_NEG  = 2'b11;

  localparam int unsigned SEL_GRA = 0;
  localparam int unsigned SEL_GRB = 1;
  localparam int unsigned SEL_GRC = 2;
  localparam int unsigned SEL_BA  = 3;

  localparam int unsigned WR_REG   = 0;
  localparam int unsigned WR_HI    = 1;
  localparam int unsigned WR_LO    = 2;
  localparam int unsigned WR_Z     = 3;
  localparam int unsigned WR_PC    = 4;
  localparam int unsigned WR_MDR   = 5;
  localparam int unsigned WR_IR    = 6;
  localparam int unsigned WR_Y     = 7;
  localparam int unsigned WR_MAR   = 8;
  localparam int unsigned WR_MEM   = 9;
  localparam int unsigned WR_OUT   = 10;
  localparam int unsigned WR_CONFF = 11;

  localparam int unsigned RD_REG  = 0;
  localparam int unsigned RD_HI   = 1;
  localparam int unsigned RD_LO   = 2;
  localparam int unsigned RD_ZLO  = 3;
  localparam int unsigned RD_ZHI  = 4;
  localparam int unsigned RD_PC   = 5;
  localparam int unsigned RD_MDR  = 6;
  localparam int unsigned RD_IN   = 7;
  localparam int unsigned RD_C    = 8;
  localparam int unsigned RD_MEM  = 9;

  localparam int unsigned DIV_WAIT_STEPS = 32;

  typedef enum logic [5:0] {
    S_RESET    = 6'd0,  S_T0       = 6'd1,  S_T1       = 6'd2,  S_T2      = 6'd3,
    S_HALT     = 6'd4,  S_ALU_Y    = 6'd5,  S_ALU_Z    = 6'd6,  S_ALUI_Z  = 6'd7,
    S_ALU_W    = 6'd8,  S_UN_Z     = 6'd9,  S_MD_LO    = 6'd10, S_MD_HI   = 6'd11,
    S_DIV_RST  = 6'd12, S_DIV_WAIT = 6'd13, S_ADR_Y    = 6'd14, S_ADR_Z   = 6'd15,
    S_ADR_MAR  = 6'd16, S_LD_MEM   = 6'd17, S_LD_W     = 6'd18, S_ST_MDR  = 6'd19,
    S_ST_MEM   = 6'd20, S_BR_CON   = 6'd21, S_BR_Y     = 6'd22, S_BR_Z    = 6'd23,
    S_BR_PC    = 6'd24, S_JR       = 6'd25, S_JAL_LINK = 6'd26, S_IN      = 6'd27,
    S_OUT      = 6'd28, S_MFHI     = 6'd29, S_MFLO     = 6'd30
  } state_e;

  typedef struct packed {
    logic        run;
    logic        clear;
    logic [3:0]  sel;
    logic [11:0] wr;
    logic [9:0]  rd;
    alu_e        alu;
    logic        div_reset;
    logic        mdr_select;
    logic        inc_pc;
  } ctrl_t;

  function automatic alu_e alu_of_op(input logic [4:0] op);
    case (op)
      OP_SUB:         return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:  return ALU_OR;
      OP_SHR:         return ALU_SHR;
      OP_SHL:         return ALU_SHL;
      OP_ROR:         return ALU_ROR;
      OP_ROL:         return ALU_ROL;
      OP_MUL:         return ALU_MUL;
      OP_DIV:         return ALU_DIV;
      OP_NEG:         return ALU_NEG;
      OP_NOT:         return ALU_NOT;
      default:        return ALU_ADD;
    endcase
  endfunction

  function automatic ctrl_t decode_ctrl(input state_e s, input logic [4:0] op);
    ctrl_t c;
    c     = '0;
    c.run = 1'b1;
    case (s)
      S_RESET:    c.clear = 1'b1;
      S_HALT:     c.run = 1'b0;
      S_T0:       begin c.rd[RD_PC] = 1'b1; c.wr[WR_MAR] = 1'b1; c.inc_pc = 1'b1; end
      S_T1:       begin c.rd[RD_MEM] = 1'b1; c.mdr_select = 1'b1; c.wr[WR_MDR] = 1'b1; end
      S_T2:       begin c.rd[RD_MDR] = 1'b1; c.wr[WR_IR] = 1'b1; end
      S_ALU_Y:    begin c.rd[RD_REG] = 1'b1; c.sel[SEL_GRB] = 1'b1; c.wr[WR_Y] = 1'b1; end
      S_ALU_Z:    begin c.rd[RD_REG] = 1'b1; c.sel[SEL_GRC] = 1'b1; c.wr[WR_Z] = 1'b1; c.alu = alu_of_op(op); end
      S_ALUI_Z:   begin c.rd[RD_C] = 1'b1; c.wr[WR_Z] = 1'b1; c.alu = alu_of_op(op); end
      S_UN_Z:     begin c.rd[RD_REG] = 1'b1; c.sel[SEL_GRB] = 1'b1; c.wr[WR_Z] = 1'b1; c.alu = alu_of_op(op); end
      S_ALU_W:    begin c.rd[RD_ZLO] = 1'b1; c.sel[SEL_GRA] = 1'b1; c.wr[WR_REG] = 1'b1; end
      S_MD_LO:    begin c.rd[RD_ZLO] = 1'b1; c.wr[WR_LO] = 1'b1; end
      S_MD_HI:    begin c.rd[RD_ZHI] = 1'b1; c.wr[WR_HI] = 1'b1; end
      // Divisor stays on the bus while the iterative divider runs.
      S_DIV_RST:  begin c.rd[RD_REG] = 1'b1; c.sel[SEL_GRC] = 1'b1; c.alu = ALU_DIV; c.div_reset = 1'b1; end
      S_DIV_WAIT: begin c.rd[RD_REG] = 1'b1; c.sel[SEL_GRC] = 1'b1; c.alu = ALU_DIV; end
      S_ADR_Y:    begin c.rd[RD_REG] = 1'b1; c.sel[SEL_GRB] = 1'b1; c.sel[SEL_BA] = 1'b1; c.wr[WR_Y] = 1'b1; end
      S_ADR_Z:    begin c.rd[RD_C] = 1'b1; c.wr[WR_Z] = 1'b1; c.alu = ALU_ADD; end
      S_ADR_MAR:  begin c.rd[RD_ZLO] = 1'b1; c.wr[WR_MAR] = 1'b1; end
      S_LD_MEM:   begin c.rd[RD_MEM] = 1'b1; c.mdr_select = 1'b1; c.wr[WR_MDR] = 1'b1; end
      S_LD_W:     begin c.rd[RD_MDR] = 1'b1; c.sel[SEL_GRA] = 1'b1; c.wr[WR_REG] = 1'b1; end
      S_ST_MDR:   begin c.rd[RD_REG] = 1'b1; c.sel[SEL_GRA] = 1'b1; c.wr[WR_MDR] = 1'b1; end
      S_ST_MEM:   c.wr[WR_MEM] = 1'b1;
      S_BR_CON:   begin c.rd[RD_REG] = 1'b1; c.sel[SEL_GRA] = 1'b1; c.wr[WR_CONFF] = 1'b1; end
      S_BR_Y:     begin c.rd[RD_PC] = 1'b1; c.wr[WR_Y] = 1'b1; end
      S_BR_Z:     begin c.rd[RD_C] = 1'b1; c.wr[WR_Z] = 1'b1; c.alu = ALU_ADD; end
      S_BR_PC:    begin c.rd[RD_ZLO] = 1'b1; c.wr[WR_PC] = 1'b1; end
      S_JR:       begin c.rd[RD_REG] = 1'b1; c.sel[SEL_GRA] = 1'b1; c.wr[WR_PC] = 1'b1; end
      S_JAL_LINK: begin c.rd[RD_PC] = 1'b1; c.sel[SEL_GRA] = 1'b1; c.wr[WR_REG] = 1'b1; end
      S_IN:       begin c.rd[RD_IN] = 1'b1; c.sel[SEL_GRA] = 1'b1; c.wr[WR_REG] = 1'b1; end
      S_OUT:      begin c.rd[RD_REG] = 1'b1; c.sel[SEL_GRA] = 1'b1; c.wr[WR_OUT] = 1'b1; end
      S_MFHI:     begin c.rd[RD_HI] = 1'b1; c.sel[SEL_GRA] = 1'b1; c.wr[WR_REG] = 1'b1; end
      S_MFLO:     begin c.rd[RD_LO] = 1'b1; c.sel[SEL_GRA] = 1'b1; c.wr[WR_REG] = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/src_con_ff.sv
// Branch condition flip-flop: latches the IR condition test of the bus when enabled.
module src_con_ff
  import src_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  cond,
  input  logic [31:0] bus,
  output logic        branch
);

  logic hit;
  logic branch_d;
  logic branch_q;

  always_comb begin
    case (cond)
      COND_ZERO: hit = (bus == '0);
      COND_NZ:   hit = (bus != '0);
      COND_POS:  hit = !bus[31] && (bus != '0);
      default:   hit = bus[31];
    endcase
    branch_d = en ? hit : branch_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) branch_q <= 1'b0;
    else     branch_q <= branch_d;
  end

  assign branch = branch_q;

endmodule

// File: rtl/src_control_core.sv
// Microcoded control unit: clock divider sets the microstep rate, the FSM sequences
// fetch/execute and registers a Moore control word decoded from the next state.
module src_control_core
  import src_pkg::*;
#(
  parameter int unsigned DIV_RATIO = 4
) (
  input  logic        clk,
  input  logic        in_reset,
  input  logic        in_stop,
  input  logic [31:0] in_ir,
  input  logic [31:0] in_bus,
  output logic        out_run,
  output logic        out_clear,
  output logic [3:0]  out_sel,
  output logic [11:0] out_wr,
  output logic [9:0]  out_rd,
  output logic [3:0]  out_alu_opcode,
  output logic        out_div_reset,
  output logic        out_mdr_select,
  output logic        out_inc_pc,
  output logic        out_branch,
  output logic        out_step_en,
  output logic [5:0]  out_state
);

  logic [7:0] cnt_d, cnt_q;
  logic [4:0] div_cnt_d, div_cnt_q;
  state_e     state_d, state_q;
  ctrl_t      ctrl_d, ctrl_q;
  state_e     fetch_st;
  logic       step_en;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = in_ir[31:27];
  assign unused_ir = ^{in_ir[26:21], in_ir[18:0]};

  always_comb begin
    step_en   = (cnt_q == 8'(DIV_RATIO - 1));
    cnt_d     = step_en ? '0 : cnt_q + 8'd1;
    fetch_st  = in_stop ? S_HALT : S_T0;
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    if (step_en) begin
      case (state_q)
        S_RESET: state_d = S_T0;
        S_T0:    state_d = in_stop ? S_HALT : S_T1;
        S_T1:    state_d = S_T2;
        S_T2: begin
          case (op)
            OP_LD, OP_LDI, OP_ST:                  state_d = S_ADR_Y;
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR,
            OP_ROL, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
            OP_ORI, OP_MUL, OP_DIV:                state_d = S_ALU_Y;
            OP_NEG, OP_NOT:                        state_d = S_UN_Z;
            OP_BR:                                 state_d = S_BR_CON;
            OP_JR:                                 state_d = S_JR;
            OP_JAL:                                state_d = S_JAL_LINK;
            OP_IN:                                 state_d = S_IN;
            OP_OUT:                                state_d = S_OUT;
            OP_MFHI:                               state_d = S_MFHI;
            OP_MFLO:                               state_d = S_MFLO;
            OP_HALT:                               state_d = S_HALT;
            default:                               state_d = fetch_st;
          endcase
        end
        S_ALU_Y: begin
          if (op == OP_DIV)
            state_d = S_DIV_RST;
          else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI)
            state_d = S_ALUI_Z;
          else
            state_d = S_ALU_Z;
        end
        S_DIV_RST: begin
          state_d   = S_DIV_WAIT;
          div_cnt_d = '0;
        end
        S_DIV_WAIT: begin
          if (div_cnt_q == 5'(DIV_WAIT_STEPS - 1)) state_d = S_ALU_Z;
          else div_cnt_d = div_cnt_q + 5'd1;
        end
        S_ALU_Z:    state_d = (op == OP_MUL || op == OP_DIV) ? S_MD_LO : S_ALU_W;
        S_ALUI_Z:   state_d = S_ALU_W;
        S_UN_Z:     state_d = S_ALU_W;
        S_ALU_W:    state_d = fetch_st;
        S_MD_LO:    state_d = S_MD_HI;
        S_MD_HI:    state_d = fetch_st;
        S_ADR_Y:    state_d = S_ADR_Z;
        S_ADR_Z:    state_d = (op == OP_LDI) ? S_ALU_W : S_ADR_MAR;
        S_ADR_MAR:  state_d = (op == OP_LD) ? S_LD_MEM : S_ST_MDR;
        S_LD_MEM:   state_d = S_LD_W;
        S_LD_W:     state_d = fetch_st;
        S_ST_MDR:   state_d = S_ST_MEM;
        S_ST_MEM:   state_d = fetch_st;
        S_BR_CON:   state_d = S_BR_Y;
        S_BR_Y:     state_d = S_BR_Z;
        // Condition was latched at the end of S_BR_CON, so it is settled here.
        S_BR_Z:     state_d = out_branch ? S_BR_PC : fetch_st;
        S_BR_PC:    state_d = fetch_st;
        S_JAL_LINK: state_d = S_JR;
        S_JR, S_IN, S_OUT, S_MFHI, S_MFLO: state_d = fetch_st;
        S_HALT:     state_d = S_HALT;
        default:    state_d = S_RESET;
      endcase
    end
    ctrl_d = decode_ctrl(state_d, op);
  end

  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) begin
      cnt_q     <= '0;
      div_cnt_q <= '0;
      state_q   <= S_RESET;
      ctrl_q    <= decode_ctrl(S_RESET, '0);
    end else begin
      cnt_q     <= cnt_d;
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
    end
  end

  src_con_ff u_con_ff (
    .clk    (clk),
    .rst    (in_reset),
    .en     (ctrl_q.wr[WR_CONFF] & step_en),
    .cond   (in_ir[20:19]),
    .bus    (in_bus),
    .branch (out_branch)
  );

  assign out_run        = ctrl_q.run;
  assign out_clear      = ctrl_q.clear;
  assign out_sel        = ctrl_q.sel;
  assign out_wr         = ctrl_q.wr;
  assign out_rd         = ctrl_q.rd;
  assign out_alu_opcode = ctrl_q.alu;
  assign out_div_reset  = ctrl_q.div_reset;
  assign out_mdr_select = ctrl_q.mdr_select;
  assign out_inc_pc     = ctrl_q.inc_pc;
  assign out_step_en    = step_en;
  assign out_state      = state_q;

endmodule

// File: tb/tb_src_control_core.sv
// Bench for src_control_core: directed and random instructions against a microstep-sequence model.
module tb_src_control_core;

  localparam int DIV = 4;

  localparam int R_REG = 0, R_HI = 1, R_LO = 2, R_ZLO = 3, R_ZHI = 4;
  localparam int R_PC = 5, R_MDR = 6, R_IN = 7, R_C = 8, R_MEM = 9;
  localparam int W_REG = 0, W_HI = 1, W_LO = 2, W_Z = 3, W_PC = 4, W_MDR = 5;
  localparam int W_IR = 6, W_Y = 7, W_MAR = 8, W_MEM = 9, W_OUT = 10, W_CON = 11;
  localparam logic [3:0] GRA = 4'b0001, GRB = 4'b0010, GRC = 4'b0100, BA = 4'b1000;

  logic        clk = 1'b0;
  logic        in_reset, in_stop;
  logic [31:0] in_ir, in_bus;
  logic        out_run, out_clear, out_div_reset, out_mdr_select, out_inc_pc;
  logic        out_branch, out_step_en;
  logic [3:0]  out_sel, out_alu_opcode;
  logic [11:0] out_wr;
  logic [9:0]  out_rd;
  logic [5:0]  out_state;

  always #5 clk = ~clk;

  src_control_core #(.DIV_RATIO(DIV)) dut (
    .clk(clk), .in_reset(in_reset), .in_stop(in_stop), .in_ir(in_ir), .in_bus(in_bus),
    .out_run(out_run), .out_clear(out_clear), .out_sel(out_sel), .out_wr(out_wr),
    .out_rd(out_rd), .out_alu_opcode(out_alu_opcode), .out_div_reset(out_div_reset),
    .out_mdr_select(out_mdr_select), .out_inc_pc(out_inc_pc), .out_branch(out_branch),
    .out_step_en(out_step_en), .out_state(out_state)
  );

  typedef struct packed {
    logic [3:0]  sel;
    logic [11:0] wr;
    logic [9:0]  rd;
    logic        mdr;
    logic        drst;
    logic        inc;
    logic        care;
    logic [3:0]  alu;
  } step_t;

  int total = 0;
  int bad   = 0;
  step_t q[$];

  function automatic logic [11:0] wb(input int i);
    logic [11:0] m;
    m = '0; m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [9:0] rb(input int i);
    logic [9:0] m;
    m = '0; m[i] = 1'b1;
    return m;
  endfunction

  function automatic step_t mk(input logic [3:0] sel, input logic [11:0] wr, input logic [9:0] rd,
                               input int alu = -1, input logic mdr = 1'b0,
                               input logic drst = 1'b0, input logic inc = 1'b0);
    step_t s;
    s.sel = sel; s.wr = wr; s.rd = rd; s.mdr = mdr; s.drst = drst; s.inc = inc;
    s.care = (alu >= 0);
    s.alu  = (alu >= 0) ? 4'(alu) : 4'd0;
    return s;
  endfunction

  function automatic int alu_code(input int op);
    case (op)
      3, 11: return 0;
      4:     return 1;
      9, 12: return 2;
      10, 13: return 3;
      5: return 4;  6: return 5;  7: return 6;  8: return 7;
      14: return 8; 15: return 9; 16: return 10; 17: return 11;
      default: return -1;
    endcase
  endfunction

  function automatic bit cond_true(input logic [1:0] c, input logic [31:0] b);
    case (c)
      2'b00: return b == 0;
      2'b01: return b != 0;
      2'b10: return (b[31] == 1'b0) && (b != 0);
      default: return b[31] == 1'b1;
    endcase
  endfunction

  // Expected execute-phase microsteps for one instruction, from the opcode table.
  function automatic void plan(input int op, input bit take);
    q.delete();
    if (op >= 3 && op <= 10) begin
      q.push_back(mk(GRB, wb(W_Y), rb(R_REG)));
      q.push_back(mk(GRC, wb(W_Z), rb(R_REG), alu_code(op)));
      q.push_back(mk(GRA, wb(W_REG), rb(R_ZLO)));
    end else if (op >= 11 && op <= 13) begin
      q.push_back(mk(GRB, wb(W_Y), rb(R_REG)));
      q.push_back(mk(4'b0, wb(W_Z), rb(R_C), alu_code(op)));
      q.push_back(mk(GRA, wb(W_REG), rb(R_ZLO)));
    end else if (op == 14 || op == 15) begin
      q.push_back(mk(GRB, wb(W_Y), rb(R_REG)));
      if (op == 15) begin
        q.push_back(mk(GRC, 12'd0, rb(R_REG), 9, 1'b0, 1'b1));
        for (int i = 0; i < 32; i++) q.push_back(mk(GRC, 12'd0, rb(R_REG), 9));
      end
      q.push_back(mk(GRC, wb(W_Z), rb(R_REG), alu_code(op)));
      q.push_back(mk(4'b0, wb(W_LO), rb(R_ZLO)));
      q.push_back(mk(4'b0, wb(W_HI), rb(R_ZHI)));
    end else if (op == 16 || op == 17) begin
      q.push_back(mk(GRB, wb(W_Z), rb(R_REG), alu_code(op)));
      q.push_back(mk(GRA, wb(W_REG), rb(R_ZLO)));
    end else if (op <= 2) begin
      q.push_back(mk(BA | GRB, wb(W_Y), rb(R_REG)));
      q.push_back(mk(4'b0, wb(W_Z), rb(R_C), 0));
      if (op == 1) q.push_back(mk(GRA, wb(W_REG), rb(R_ZLO)));
      else q.push_back(mk(4'b0, wb(W_MAR), rb(R_ZLO)));
      if (op == 0) begin
        q.push_back(mk(4'b0, wb(W_MDR), rb(R_MEM), -1, 1'b1));
        q.push_back(mk(GRA, wb(W_REG), rb(R_MDR)));
      end else if (op == 2) begin
        q.push_back(mk(GRA, wb(W_MDR), rb(R_REG)));
        q.push_back(mk(4'b0, wb(W_MEM), 10'd0));
      end
    end else begin
      case (op)
        18: begin
          q.push_back(mk(GRA, wb(W_CON), rb(R_REG)));
          q.push_back(mk(4'b0, wb(W_Y), rb(R_PC)));
          q.push_back(mk(4'b0, wb(W_Z), rb(R_C), 0));
          if (take) q.push_back(mk(4'b0, wb(W_PC), rb(R_ZLO)));
        end
        19: q.push_back(mk(GRA, wb(W_PC), rb(R_REG)));
        20: begin
          q.push_back(mk(GRA, wb(W_REG), rb(R_PC)));
          q.push_back(mk(GRA, wb(W_PC), rb(R_REG)));
        end
        21: q.push_back(mk(GRA, wb(W_REG), rb(R_IN)));
        22: q.push_back(mk(GRA, wb(W_OUT), rb(R_REG)));
        23: q.push_back(mk(GRA, wb(W_REG), rb(R_HI)));
        24: q.push_back(mk(GRA, wb(W_REG), rb(R_LO)));
        default: ;
      endcase
    end
  endfunction

  task automatic check_word(input string tag, input logic run, input logic clr, input step_t e);
    logic [30:0] obs, exp;
    obs = {out_run, out_clear, out_sel, out_wr, out_rd, out_mdr_select, out_div_reset, out_inc_pc};
    exp = {run, clr, e.sel, e.wr, e.rd, e.mdr, e.drst, e.inc};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s ctrl got=%h exp=%h", tag, obs, exp);
    end
    if (e.care) begin
      total++;
      assert (out_alu_opcode === e.alu) else begin
        bad++;
        $error("FAIL %s alu got=%0d exp=%0d", tag, out_alu_opcode, e.alu);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next microstep boundary (bounded wait).
  task automatic wait_step();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (out_step_en !== 1'b1 && n < 400);
    check_bit("step_timeout", out_step_en, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    #1;
    check_word("reset_ctrl", 1'b1, 1'b1, mk(4'b0, 12'd0, 10'd0));
    check_bit("reset_branch", out_branch, 1'b0);
    check_bit("reset_step_en", out_step_en, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_reset = 1'b0;
  endtask

  task automatic check_fetch(input logic [31:0] ir, input logic [31:0] bus);
    in_ir = ir;
    in_bus = bus;
    check_word("t0", 1'b1, 1'b0, mk(4'b0, wb(W_MAR), rb(R_PC), -1, 1'b0, 1'b0, 1'b1));
    wait_step();
    check_word("t1", 1'b1, 1'b0, mk(4'b0, wb(W_MDR), rb(R_MEM), -1, 1'b1));
    wait_step();
    check_word("t2", 1'b1, 1'b0, mk(4'b0, wb(W_IR), rb(R_MDR)));
  endtask

  task automatic check_halted(input string tag, input int steps);
    for (int i = 0; i < steps; i++) begin
      check_word(tag, 1'b0, 1'b0, mk(4'b0, 12'd0, 10'd0));
      wait_step();
    end
  endtask

  // Entered at the start of T0; leaves at the start of the following T0 or HALT.
  task automatic run_instr(input logic [31:0] ir, input logic [31:0] bus);
    int op, idx;
    bit take;
    step_t e;
    op = int'(ir[31:27]);
    take = cond_true(ir[20:19], bus);
    check_fetch(ir, bus);
    plan(op, take);
    idx = 0;
    while (q.size() > 0) begin
      wait_step();
      e = q.pop_front();
      check_word($sformatf("op%0d_s%0d", op, idx), 1'b1, 1'b0, e);
      if (op == 18 && idx == 1) check_bit($sformatf("branch_c%0d", ir[20:19]), out_branch, take);
      idx++;
    end
    wait_step();
  endtask

  function automatic logic [31:0] mk_ir(input int op, input logic [1:0] c);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = 5'(op);
    r[20:19] = c;
    return r;
  endfunction

  initial begin
    int n, op;
    logic [31:0] bus;
    in_reset = 1'b1; in_stop = 1'b0; in_ir = '0; in_bus = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Step period: count clocks between two pulses.
    n = 0;
    do begin @(negedge clk); n++; end while (out_step_en !== 1'b1 && n < 50);
    n = 0;
    do begin @(negedge clk); n++; end while (out_step_en !== 1'b1 && n < 50);
    total++;
    assert (n === DIV) else begin bad++; $error("FAIL step_period got=%0d exp=%0d", n, DIV); end
    @(posedge clk); #1;
    do_reset();
    wait_step();

    run_instr(32'h1800_0000, 32'h0);
    run_instr(mk_ir(18, 2'b00), 32'h0);
    run_instr(mk_ir(18, 2'b00), 32'h5);
    run_instr(mk_ir(18, 2'b11), 32'h8000_0000);
    run_instr(mk_ir(18, 2'b11), 32'h0000_0001);
    run_instr(mk_ir(18, 2'b10), 32'h0000_0007);
    run_instr(mk_ir(18, 2'b01), 32'h0);
    for (int k = 0; k <= 31; k++) begin
      if (k != 26) run_instr(mk_ir(k, 2'($urandom)), $urandom);
    end
    for (int k = 0; k < 40; k++) begin
      do op = int'($urandom_range(0, 31)); while (op == 26);
      case ($urandom_range(0, 3))
        0: bus = 32'h0;
        1: bus = 32'h8000_0000 | $urandom;
        2: bus = $urandom_range(1, 9);
        default: bus = $urandom;
      endcase
      run_instr(mk_ir(op, 2'($urandom)), bus);
    end

    // Reset in the middle of a divide aborts immediately and restarts at T0.
    check_fetch(mk_ir(15, 2'b00), 32'h0);
    repeat (5) wait_step();
    @(posedge clk); #1;
    check_word("div_mid", 1'b1, 1'b0, mk(GRC, 12'd0, rb(R_REG), 9));
    do_reset();
    wait_step();
    run_instr(32'h1800_0000, 32'h0);

    // in_stop seen in T0 halts.
    in_stop = 1'b1;
    wait_step();
    in_stop = 1'b0;
    check_halted("stop_halt", 3);
    do_reset();
    wait_step();

    // halt opcode stays halted until reset.
    check_fetch(mk_ir(26, 2'b00), 32'h0);
    wait_step();
    check_halted("op_halt", 4);
    do_reset();
    wait_step();
    run_instr(mk_ir(9, 2'b00), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/src_control_core.md
SRC_CONTROL_CORE -- requirements
Module: src_control_core

Interface
REQ-001 DIV_RATIO, default 4, clk cycles per microstep (legal 1..255).
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 in_reset  in  1  asynchronous, active-high reset.
REQ-004 in_stop  in  1  synchronous halt request, active-high, sampled on each microstep.
REQ-005 in_ir  in  32  instruction register; opcode [31:27], condition [20:19].
REQ-006 in_bus  in  32  datapath bus value, tested by the condition flip-flop.
REQ-007 out_run  out  1  high while executing; low in HALT.
REQ-008 out_clear  out  1  datapath register clear.
REQ-009 out_sel  out  4  {ba_read, grc, grb, gra} register-select strobes.
REQ-010 out_wr  out  12  write strobes, bit 0..11 = regfile, hi, lo, z, pc, mdr, ir, y, mar, mem, outport, conff.
REQ-011 out_rd  out  10  bus-drive strobes, bit 0..9 = regfile, hi, lo, z_lo, z_hi, pc, mdr, inport, c, mem.
REQ-012 out_alu_opcode  out  4  0 add, 1 sub, 2 and, 3 or, 4 shr, 5 shl, 6 ror, 7 rol, 8 mul, 9 div, 10 neg, 11 not.
REQ-013 out_div_reset, out_mdr_select (1 = memory), out_inc_pc  out  1 each.
REQ-014 out_branch  out  1  condition flip-flop state.
REQ-015 out_step_en  out  1  one-clk pulse marking each microstep boundary.
REQ-016 out_state  out  6  current state code.

Function
REQ-017 A modulo-DIV_RATIO counter SHALL pulse out_step_en once every DIV_RATIO clk cycles; the FSM SHALL advance only on that pulse.
REQ-018 All control outputs SHALL be Moore-decoded from the state and SHALL stay stable for the whole microstep.
REQ-019 Opcodes: ld 0, ldi 1, st 2, add 3, sub 4, shr 5, shl 6, ror 7, rol 8, and 9, or 10, addi 11, andi 12, ori 13, mul 14, div 15, neg 16, not 17, br 18, jr 19, jal 20, in 21, out 22, mfhi 23, mflo 24, nop 25, halt 26; other values SHALL behave as nop.
REQ-020 Fetch: T0 = pc rd + mar wr + inc_pc; T1 = mem rd + mdr_select + mdr wr; T2 = mdr rd + ir wr.
REQ-021 Register-register ALU ops: grb rd + y wr; grc rd + alu op + z wr; z_lo rd + gra + regfile wr.
REQ-022 Immediate ALU ops SHALL use the sequence in REQ-021 with c rd replacing grc rd.
REQ-023 mul/div SHALL write z and then move z_lo to lo and z_hi to hi.
REQ-024 div SHALL assert out_div_reset for one step before the z-write step, and z wr SHALL occur in the 33rd subsequent step.
REQ-025 ld/ldi/st SHALL form the address as grb or ba_read into y, add c into z, then z_lo into mar.
REQ-026 ld SHALL then perform the memory read into mdr and write mdr to gra.
REQ-027 ldi SHALL write z_lo to gra; st SHALL drive gra onto the bus into mdr (mdr_select 0) and then assert mem wr.
REQ-028 br SHALL assert gra rd + conff wr, then pc rd + y wr, then c rd + add + z wr.
REQ-029 br SHALL write z_lo to pc only if out_branch=1.
REQ-030 jal SHALL write pc to r15 (gra forced) and then gra to pc; jr SHALL write gra to pc.
REQ-031 in/out/mfhi/mflo SHALL each be a single transfer: inport, gra to outport, hi, lo respectively.
REQ-032 After each execute sequence the FSM SHALL return to T0.
REQ-033 halt, or in_stop=1 at a T0 boundary, SHALL enter HALT: out_run=0, all strobes 0; HALT is left only by reset.
REQ-034 On conff wr the flip-flop SHALL latch the condition (IR[20:19]: 00 bus==0, 01 bus!=0, 10 bus[31]==0 and bus!=0, 11 bus[31]==1) and hold it otherwise.

Reset
REQ-035 Reset SHALL force RESET state (out_clear=1, out_run=1), divider count 0, out_branch 0 and all other strobes 0.
REQ-036 The first microstep after reset release SHALL go to T0.
REQ-037 Reset asserted mid-instruction SHALL abort the instruction immediately.

Structure
REQ-038 Opcode, ALU-code, state-code and strobe bit-index constants SHALL reside in package src_pkg.
REQ-039 The condition flip-flop SHALL be sub-module src_con_ff; the divider and FSM SHALL be inline.

Verification
REQ-040 DIV_RATIO=4, reset released: out_step_en pulses every 4 clk cycles; T0 shows pc rd, mar wr, inc_pc.
REQ-041 IR=0x18000000 (add r0) during T2: z_lo rd + regfile wr with gra occur 3 steps after T2.
REQ-042 br with IR[20:19]=00 and bus=0: out_branch=1 and pc wr asserted; with bus=5: no pc wr.
REQ-043 Condition 11 with bus=0x80000000: out_branch=1; with bus=0x00000001: out_branch=0.
REQ-044 Opcode 26 (halt): out_run=0 and the FSM stays in HALT until reset; in_stop=1 at T0 gives the same result.
REQ-045 Reset asserted during the div count: all strobes 0 at once, then restart at T0.
